// File: rtl/sm83_bus_responder.sv
// -----------------------------------------------------------------------------
// sm83_bus_responder
//
// Target side of the sm83 memory bus. Each CPU request is one read or write.
//   - FF80-FFFE : 127-byte HRAM, served locally
//   - FFFF      : IE register, served locally (only IE_MASK bits are stored)
//   - FEA0-FEFF : unmapped; reads return UNMAPPED_DATA, writes are dropped
//   - elsewhere : forwarded to the external memory port via ext_req/ext_ack
//
// Ports
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   cpu_req                level request; address/data/direction held until cpu_ready
//   cpu_addr/wdata/write   transaction address, write data, 1=write
//   cpu_rdata              read data, valid with cpu_ready on a read
//   cpu_ready              one-cycle completion pulse
//   ext_req                external request, held until ext_ack or timeout
//   ext_addr/wdata/write   registered copies of the accepted transaction
//   ext_ack, ext_rdata     external completion and read data (same cycle)
//   ie_reg                 current IE value for the interrupt logic
//
// Timing
//   Local access : accept -> LOCAL -> RESP, cpu_ready two cycles after accept.
//   External     : accept -> EXT_WAIT (ext_req high) until ack or TIMEOUT_CYCLES
//                  ack-less cycles, then RESP. An ack on the final cycle wins.
//   RESP is always followed by at least one IDLE cycle.
// -----------------------------------------------------------------------------
module sm83_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  UNMAPPED_DATA  = 8'hFF,
    parameter logic [7:0]  IE_MASK        = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_write,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  ie_reg
);

    localparam int unsigned    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCAL    = 2'd1,
        ST_EXT_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    state_t             state_q;
    logic [7:0]         cpu_rdata_q;
    logic               cpu_ready_q;
    logic               ext_req_q;
    logic [15:0]        ext_addr_q;
    logic [7:0]         ext_wdata_q;
    logic               ext_write_q;
    logic [7:0]         ie_q;
    logic [CNT_W-1:0]   tmo_cnt_q;
    logic [CNT_W-1:0]   tmo_cnt_d;

    // HRAM is deliberately left out of reset so it maps onto plain RAM.
    logic [7:0]         hram_q [0:126];

    logic               ie_hit_d;
    logic               hram_hit_d;
    logic [7:0]         local_rdata_d;

    // FF80-FFFF and FEA0-FEFF are answered without touching the external port.
    function automatic logic is_local_region(input logic [15:0] a);
        logic hi_page;
        logic unmapped;
        hi_page  = (a[15:7] == 9'h1FF);
        unmapped = (a[15:8] == 8'hFE) && (a[7:0] >= 8'hA0);
        return hi_page || unmapped;
    endfunction

    // Decode of the latched address, used in LOCAL.
    always_comb begin
        ie_hit_d      = (ext_addr_q == 16'hFFFF);
        hram_hit_d    = (ext_addr_q[15:7] == 9'h1FF) && !ie_hit_d;
        tmo_cnt_d     = tmo_cnt_q + CNT_ONE;
        local_rdata_d = UNMAPPED_DATA;
        if (ie_hit_d) begin
            local_rdata_d = ie_q;
        end else if (hram_hit_d) begin
            local_rdata_d = hram_q[ext_addr_q[6:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_LOCAL && ext_write_q && hram_hit_d) begin
            hram_q[ext_addr_q[6:0]] <= ext_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cpu_rdata_q <= 8'h00;
            cpu_ready_q <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            ext_write_q <= 1'b0;
            ie_q        <= 8'h00;
            tmo_cnt_q   <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        ext_addr_q  <= cpu_addr;
                        ext_wdata_q <= cpu_wdata;
                        ext_write_q <= cpu_write;
                        if (is_local_region(cpu_addr)) begin
                            state_q <= ST_LOCAL;
                        end else begin
                            state_q   <= ST_EXT_WAIT;
                            ext_req_q <= 1'b1;
                            tmo_cnt_q <= '0;
                        end
                    end
                end

                ST_LOCAL: begin
                    state_q     <= ST_RESP;
                    cpu_ready_q <= 1'b1;
                    if (!ext_write_q) begin
                        cpu_rdata_q <= local_rdata_d;
                    end else if (ie_hit_d) begin
                        ie_q <= ext_wdata_q & IE_MASK;
                    end
                end

                ST_EXT_WAIT: begin
                    // Ack is checked first so it wins on the timeout cycle.
                    if (ext_ack) begin
                        state_q     <= ST_RESP;
                        ext_req_q   <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        if (!ext_write_q) begin
                            cpu_rdata_q <= ext_rdata;
                        end
                    end else if (tmo_cnt_d == CNT_LIMIT) begin
                        state_q     <= ST_RESP;
                        ext_req_q   <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        if (!ext_write_q) begin
                            cpu_rdata_q <= UNMAPPED_DATA;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign ext_req   = ext_req_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign ext_write = ext_write_q;
    assign ie_reg    = ie_q;

endmodule
